exc_redirect_ctrl: RTL and testbench
====================================

Name: exc_redirect_ctrl

Overview:
- Sits between the CP0 exception/eret outputs and the IF stage's SRAM-like instruction port.
- On an exception or eret it:
  - issues a one-cycle pipeline flush;
  - holds new fetches and drains any instruction-fetch responses already in flight, discarding them;
  - presents the redirect PC to IF until IF accepts it.
- Prevents stale fetch data from entering the pipeline after a redirect.

Parameters:
EXC_ENTRY, 32'hbfc00380, exception handler entry PC (BEV=1)
OUTS_W, 2, width of the outstanding-fetch counter (max 2^OUTS_W-1 in flight)

Ports:
clk  in  1  clock, all state updates on posedge
resetn  in  1  asynchronous active-low reset
exception  in  1  CP0 exception/interrupt request, level, sampled each cycle
eret  in  1  eret decoded in ID, level
epc  in  32  current CP0 EPC value
inst_req  in  1  IF's instruction request to SRAM-like bus
inst_addr_ok  in  1  bus accepted address
inst_data_ok  in  1  bus returned data
flush  out  1  one-cycle pulse: clear valid bits of IF/ID/EX/MEM/WB
fetch_hold  out  1  IF must not raise inst_req except for the redirect address
discard  out  1  current inst_data_ok beat is stale; IF must drop it
redirect_valid  out  1  redirect_pc is valid, IF must fetch it next
redirect_pc  out  32  target PC
busy  out  1  state != IDLE

Behaviour:
- Reset (resetn low, async):
  - state=IDLE, outs_cnt=0, target=0.
  - All outputs 0; redirect_pc=0.
- outs_cnt (OUTS_W bits), updated in every state:
  - +1 on inst_req&inst_addr_ok; -1 on inst_data_ok; both in the same cycle → unchanged.
  - Saturates at max (further accept ignored) and at 0 (data_ok at 0 ignored, discard stays 0).
- States: IDLE, FLUSH, DRAIN, ISSUE.
- IDLE:
  - exception=1 → target=EXC_ENTRY, go to FLUSH.
  - else eret=1 → target=epc (sampled this edge), go to FLUSH.
  - exception has priority over eret when both are asserted.
- FLUSH (exactly 1 cycle):
  - flush=1, fetch_hold=1.
  - Next state: DRAIN if outs_cnt_next!=0, else ISSUE. outs_cnt_next is the count after this cycle's inc/dec.
- DRAIN:
  - fetch_hold=1; discard=inst_data_ok.
  - Leave to ISSUE the cycle outs_cnt_next==0.
  - Fetch data arriving in FLUSH is also stale: discard=inst_data_ok in FLUSH.
- ISSUE:
  - redirect_valid=1, redirect_pc=target; fetch_hold=0.
  - Redirect is consumed when inst_req&inst_addr_ok → IDLE next cycle. That beat's data is not discarded.
- Events arriving in FLUSH/DRAIN/ISSUE are ignored; target is not overwritten.
- busy=1 in every state except IDLE.
- All outputs are decoded from registered state and counter only (Moore), except discard, which is gated combinationally by inst_data_ok.
- Latency:
  - event at edge N → flush in cycle N+1.
  - With no outstanding fetch, redirect_valid from cycle N+2.
- Async reset mid-operation returns immediately to IDLE with outs_cnt=0. Bus state is the integrator's responsibility.

Test Plan:
- Exception with outs_cnt=0 → flush=1 one cycle after the event, redirect_valid=1/redirect_pc=32'hbfc00380 the next cycle. IF accepts (req&addr_ok) → busy=0 the following cycle.
- eret with epc=32'hbfc00100, one fetch outstanding → flush, DRAIN until data_ok (discard=1 on that beat), then redirect_pc=32'hbfc00100.
- exception and eret asserted in the same cycle, epc=32'h12345678 → redirect_pc=32'hbfc00380.
- Two fetches outstanding; one new accept and one data_ok in the same cycle during FLUSH → count stays 2. Exactly two further discards, then ISSUE.
- Second exception pulse during DRAIN with epc changing → target unchanged, only one flush pulse.
- resetn low while in DRAIN with outs_cnt=1 → all outputs 0 immediately. After release, a data_ok yields discard=0 and the count stays 0.

Source files
------------

// File: rtl/exc_redirect_ctrl.sv
// Exception/eret redirect controller: flushes the pipeline, drains stale instruction-fetch
// responses, then presents the redirect PC to IF until the fetch of that address is accepted.
module exc_redirect_ctrl #(
  parameter logic [31:0] EXC_ENTRY = 32'hbfc00380,
  parameter int unsigned OUTS_W    = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        inst_req,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  output logic        flush,
  output logic        fetch_hold,
  output logic        discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StFlush, StDrain, StIssue} state_e;

  localparam logic [OUTS_W-1:0] CntMax = {OUTS_W{1'b1}};

  state_e            state_q, state_d;
  logic [OUTS_W-1:0] cnt_q, cnt_d;
  logic [31:0]       target_q, target_d;
  logic              accept, resp;

  assign accept = inst_req & inst_addr_ok;
  assign resp   = inst_data_ok;

  // Simultaneous accept and response cancel; otherwise saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !resp) begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else if (resp && !accept) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      StIdle: begin
        if (exception) begin
          target_d = EXC_ENTRY;
          state_d  = StFlush;
        end else if (eret) begin
          target_d = epc;
          state_d  = StFlush;
        end
      end
      StFlush: state_d = (cnt_d != '0) ? StDrain : StIssue;
      StDrain: begin
        if (cnt_d == '0) state_d = StIssue;
      end
      StIssue: begin
        if (accept) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    flush          = (state_q == StFlush);
    fetch_hold     = (state_q == StFlush) || (state_q == StDrain);
    redirect_valid = (state_q == StIssue);
    redirect_pc    = (state_q == StIssue) ? target_q : 32'h0;
    busy           = (state_q != StIdle);
    // Responses during flush/drain belong to the squashed fetch stream.
    discard        = fetch_hold && inst_data_ok && (cnt_q != '0);
  end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed self-checking bench for exc_redirect_ctrl.
module tb_exc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        exception, eret;
  logic [31:0] epc;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic        flush, fetch_hold, discard, redirect_valid, busy;
  logic [31:0] redirect_pc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  exc_redirect_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .exception     (exception),
    .eret          (eret),
    .epc           (epc),
    .inst_req      (inst_req),
    .inst_addr_ok  (inst_addr_ok),
    .inst_data_ok  (inst_data_ok),
    .flush         (flush),
    .fetch_hold    (fetch_hold),
    .discard       (discard),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    exception    = 1'b0;
    eret         = 1'b0;
    inst_req     = 1'b0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
  endtask

  task automatic acc(input logic v);
    inst_req     = v;
    inst_addr_ok = v;
  endtask

  // Packs Moore outputs: {flush, fetch_hold, redirect_valid, busy}.
  function automatic logic [31:0] st();
    return {28'h0, flush, fetch_hold, redirect_valid, busy};
  endfunction

  initial begin
    resetn = 1'b0;
    epc    = 32'h0;
    clr();
    #1;
    check("reset_outs", st(), 32'h0);
    check("reset_pc", redirect_pc, 32'h0);
    check("reset_discard", {31'h0, discard}, 32'h0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Exception, nothing outstanding.
    exception = 1'b1;
    tick();
    clr();
    check("t1_flush", st(), 32'b1101);
    tick();
    check("t1_issue", st(), 32'b0011);
    check("t1_pc", redirect_pc, 32'hbfc00380);
    acc(1'b1);
    tick();
    clr();
    check("t1_idle", st(), 32'h0);
    inst_data_ok = 1'b1;
    #1 check("t1_nodiscard", {31'h0, discard}, 32'h0);
    tick();
    clr();

    // eret with one fetch outstanding.
    epc  = 32'hbfc00100;
    eret = 1'b1;
    acc(1'b1);
    tick();
    clr();
    epc = 32'h0;
    check("t2_flush", st(), 32'b1101);
    tick();
    check("t2_drain", st(), 32'b0101);
    tick();
    check("t2_drain_hold", st(), 32'b0101);
    inst_data_ok = 1'b1;
    #1 check("t2_discard", {31'h0, discard}, 32'h1);
    tick();
    clr();
    check("t2_issue", st(), 32'b0011);
    check("t2_pc", redirect_pc, 32'hbfc00100);
    acc(1'b1);
    tick();
    clr();
    inst_data_ok = 1'b1;
    #1 check("t2_keep_beat", {31'h0, discard}, 32'h0);
    tick();
    clr();

    // Exception wins over eret.
    epc       = 32'h12345678;
    exception = 1'b1;
    eret      = 1'b1;
    tick();
    clr();
    tick();
    check("t3_pc", redirect_pc, 32'hbfc00380);
    acc(1'b1);
    tick();
    clr();
    inst_data_ok = 1'b1;
    tick();
    clr();

    // Two outstanding, accept + response together during FLUSH.
    acc(1'b1);
    tick();
    tick();
    clr();
    exception = 1'b1;
    tick();
    clr();
    acc(1'b1);
    inst_data_ok = 1'b1;
    #1 check("t4_flush_discard", {31'h0, discard}, 32'h1);
    tick();
    clr();
    check("t4_drain", st(), 32'b0101);
    inst_data_ok = 1'b1;
    #1 check("t4_discard1", {31'h0, discard}, 32'h1);
    tick();
    check("t4_still_drain", st(), 32'b0101);
    #1 check("t4_discard2", {31'h0, discard}, 32'h1);
    tick();
    clr();
    check("t4_issue", st(), 32'b0011);
    acc(1'b1);
    tick();
    clr();
    inst_data_ok = 1'b1;
    tick();
    clr();

    // Second exception during DRAIN must not retarget or reflush.
    epc  = 32'h80001000;
    eret = 1'b1;
    acc(1'b1);
    tick();
    clr();
    exception = 1'b1;
    epc       = 32'h0bad0000;
    tick();
    check("t5_drain1", st(), 32'b0101);
    tick();
    check("t5_drain2", st(), 32'b0101);
    exception    = 1'b0;
    inst_data_ok = 1'b1;
    tick();
    clr();
    check("t5_issue", st(), 32'b0011);
    check("t5_pc", redirect_pc, 32'h80001000);
    acc(1'b1);
    tick();
    clr();
    inst_data_ok = 1'b1;
    tick();
    clr();

    // Async reset while draining.
    exception = 1'b1;
    acc(1'b1);
    tick();
    clr();
    tick();
    check("t6_drain", st(), 32'b0101);
    #2 resetn = 1'b0;
    inst_data_ok = 1'b1;
    #1;
    check("t6_rst_outs", st(), 32'h0);
    check("t6_rst_discard", {31'h0, discard}, 32'h0);
    #1 resetn = 1'b1;
    tick();
    clr();
    exception = 1'b1;
    tick();
    clr();
    check("t6_flush", st(), 32'b1101);
    tick();
    // A count left nonzero would have sent the FSM to DRAIN instead.
    check("t6_cnt_zero", st(), 32'b0011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
